// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI-stream lane blocks.
package axi_stream_pkg;

  // Width of a lane index. It never drops to zero, so a
  // single-lane configuration still has a legal index vector.
  function automatic int lane_idx_w(input int parallelism);
    return (parallelism > 1) ? $clog2(parallelism) : 1;
  endfunction

  localparam int DEFAULT_PARALLELISM = 4;
  localparam int LANE_IDX_W          = lane_idx_w(DEFAULT_PARALLELISM);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/axi_stream_if.sv
// Multi-lane AXI-stream bundle: PARALLELISM lanes of DATA_WIDTH bits,
// with a per-lane mask and a packet-level last flag.
interface axi_stream_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4
);
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data;
  logic                                   valid;
  logic                                   ready;
  logic                                   last;
  logic [PARALLELISM-1:0]                 mask;

  modport master (output data, valid, last, mask, input ready);
  modport slave  (input data, valid, last, mask, output ready);
endinterface

// File: rtl/axi_stream_lane_unpacker_lane_priority_enc.sv
// Lowest-set-bit encoder. Compaction blocks use it to pick the next live lane.
module lane_priority_enc
  import axi_stream_pkg::*;
#(
  parameter  int PARALLELISM = 4,
  localparam int SEL_W       = lane_idx_w(PARALLELISM)
) (
  input  logic [PARALLELISM-1:0] i_req,
  output logic [SEL_W-1:0]       o_sel,
  output logic                   o_found
);

  // Scan from the top lane down so that the lowest set lane is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop. A path that leaves
    // o_sel unassigned would infer a latch.
    o_sel   = '0;
    o_found = |i_req;
    for (int i = PARALLELISM - 1; i >= 0; i--) begin
      if (i_req[i]) o_sel = SEL_W'(i);
    end
  end

endmodule

// File: rtl/axi_stream_lane_unpacker.sv
// Wide-to-scalar AXI-stream unpacker. It holds one wide beat and emits its
// live lanes one per cycle, lowest lane first. Masked-off lanes are
// skipped, and the packet last flag goes out on the final live lane.
module axi_stream_lane_unpacker
  import axi_stream_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int PARALLELISM = 4,
  localparam int SEL_W       = lane_idx_w(PARALLELISM)
) (
  input  logic           clk,
  input  logic           rst_n,
  axi_stream_if.slave    s_axis,
  axi_stream_if.master   m_axis,
  output logic           empty_last_o
);

  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] r_beat;
  logic [PARALLELISM-1:0]                 r_rem;
  logic                                   r_last;
  logic                                   r_empty_last;

  logic [SEL_W-1:0]       w_sel;
  logic                   w_found;
  logic [PARALLELISM-1:0] w_rem_next;
  logic                   w_out_fire;
  logic                   w_in_ready;
  logic                   w_in_fire;

  lane_priority_enc #(
    .PARALLELISM (PARALLELISM)
  ) u_lane_priority_enc (
    .i_req   (r_rem),
    .o_sel   (w_sel),
    .o_found (w_found)
  );

  // Clearing the lowest set bit is the same as clearing lane w_sel.
  assign w_rem_next = r_rem & (r_rem - PARALLELISM'(1));

  assign w_out_fire = w_found && m_axis.ready;
  // The path from m_axis.ready to s_axis.ready is combinational. A new beat
  // can load in the same cycle the final lane leaves, so no bubble appears.
  assign w_in_ready = (r_rem == '0) || (w_out_fire && (w_rem_next == '0));
  assign w_in_fire  = s_axis.valid && w_in_ready;

  assign s_axis.ready = w_in_ready;

  assign m_axis.valid = w_found;
  assign m_axis.data  = r_beat[w_sel];
  assign m_axis.mask  = w_found;
  assign m_axis.last  = r_last && (w_rem_next == '0) && w_found;

  assign empty_last_o = r_empty_last;

  // Control state. A newly accepted beat overrides the drain of the old one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values.
    if (!rst_n) begin
      r_rem        <= '0;
      r_last       <= 1'b0;
      r_empty_last <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_rem  <= s_axis.mask;
        r_last <= s_axis.last;
      end else if (w_out_fire) begin
        r_rem  <= w_rem_next;
      end
      r_empty_last <= w_in_fire && s_axis.last && (s_axis.mask == '0);
    end
  end

  // Beat payload capture.
  // NOTE: the payload has no reset. r_rem == 0 already marks it dead, and
  // leaving out the reset keeps the wide register a plain enable-flop array.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_beat <= s_axis.data;
  end

endmodule

// File: tb/tb_axi_stream_lane_unpacker.sv
// Self-checking bench for axi_stream_lane_unpacker. It uses a queue
// scoreboard that is filled when beats are driven and drained by an
// output monitor.
module tb_axi_stream_lane_unpacker;

  localparam int DW = 32;
  localparam int P  = 4;

  typedef logic [P-1:0][DW-1:0] beat_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic empty_last;

  always #5 clk = ~clk;

  axi_stream_if #(.DATA_WIDTH(DW), .PARALLELISM(P)) s_if ();
  axi_stream_if #(.DATA_WIDTH(DW), .PARALLELISM(1)) m_if ();

  axi_stream_lane_unpacker #(
    .DATA_WIDTH  (DW),
    .PARALLELISM (P)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .empty_last_o (empty_last)
  );

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            pops = 0;
  int            empty_pulses = 0;
  int            exp_empty = 0;
  bit            log_en = 0;
  int            log_cyc[$];
  logic [DW-1:0] log_data[$];
  logic          log_sready[$];
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  bit            rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor. It samples on the falling edge, checks the stream
  // against the scoreboard and checks that a stalled output holds steady.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      stall_q = 1'b0;
    end else begin
      if (empty_last === 1'b1) empty_pulses++;
      if (stall_q && m_if.valid === 1'b1) begin
        n_cmp++;
        if (m_if.data[0] !== stall_data || m_if.last !== stall_last) begin
          n_bad++;
          $display("FAIL hold_stable: got data=%h last=%b, need data=%h last=%b",
                   m_if.data[0], m_if.last, stall_data, stall_last);
        end
      end
      if (m_if.valid === 1'b1) begin
        n_cmp++;
        if (m_if.mask !== 1'b1) begin
          n_bad++;
          $display("FAIL out_mask: got %b, need 1", m_if.mask);
        end
      end
      if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_out: got data=%h last=%b, need no output",
                   m_if.data[0], m_if.last);
        end else begin
          e = sb.pop_front();
          pops++;
          if (m_if.data[0] !== e.data || m_if.last !== e.last) begin
            n_bad++;
            $display("FAIL out_elem: got data=%h last=%b, need data=%h last=%b",
                     m_if.data[0], m_if.last, e.data, e.last);
          end
          if (log_en) begin
            log_cyc.push_back(cyc);
            log_data.push_back(m_if.data[0]);
            log_sready.push_back(s_if.ready);
          end
        end
      end
      stall_q    = (m_if.valid === 1'b1) && (m_if.ready !== 1'b1);
      stall_data = m_if.data[0];
      stall_last = m_if.last;
    end
  end

  // Presents one beat, queues its expected lanes and returns just after the
  // edge that accepts it. Valid stays high, so calls can run back to back.
  task automatic send_beat(input beat_t d, input logic [P-1:0] m, input logic l);
    int   w;
    logic lf;
    s_if.data  = d;
    s_if.mask  = m;
    s_if.last  = l;
    s_if.valid = 1'b1;
    for (int i = 0; i < P; i++) begin
      if (m[i]) begin
        lf = l && ((m >> (i + 1)) == '0);
        sb.push_back(exp_t'{data: d[i], last: lf});
      end
    end
    if (m == '0 && l) exp_empty++;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (s_if.ready !== 1'b1 && w < 200);
    if (s_if.ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got ready=%b, need 1 within 200 cycles", s_if.ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_if.valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int w;
    w = 0;
    while (sb.size() > 0 && w < bound) begin
      @(negedge clk);
      #1;
      w++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, need 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    s_if.valid  = 1'b0;
    s_if.data   = '0;
    s_if.mask   = '0;
    s_if.last   = 1'b0;
    m_if.ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (m_if.valid !== 1'b0 || m_if.last !== 1'b0 || m_if.mask !== 1'b0 || empty_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b l=%b m=%b e=%b, need all 0",
               m_if.valid, m_if.last, m_if.mask, empty_last);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (s_if.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b, need 1", s_if.ready);
    end
  endtask

  task automatic test_back_to_back();
    beat_t b0, b1;
    for (int i = 0; i < P; i++) begin
      b0[i] = DW'(32'h10 + i);
      b1[i] = DW'(32'h20 + i);
    end
    log_cyc.delete(); log_data.delete(); log_sready.delete();
    log_en     = 1;
    m_if.ready = 1'b1;
    send_beat(b0, 4'b1111, 1'b0);
    send_beat(b1, 4'b1111, 1'b1);
    idle();
    drain(50);
    log_en = 0;
    n_cmp++;
    if (log_cyc.size() != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d outputs, need 8", log_cyc.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        n_cmp++;
        if (log_cyc[i] != log_cyc[0] + i) begin
          n_bad++;
          $display("FAIL b2b_gap: output %0d at cycle %0d, need %0d", i, log_cyc[i], log_cyc[0] + i);
        end
      end
      n_cmp++;
      if (log_data[3] !== 32'h13 || log_sready[3] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready_on_last_lane: got data=%h ready=%b, need data=13 ready=1",
                 log_data[3], log_sready[3]);
      end
    end
  endtask

  task automatic test_sparse();
    beat_t d;
    d[0] = 32'hAAAA_0000; d[1] = 32'hBBBB_0001;
    d[2] = 32'hCCCC_0002; d[3] = 32'hDDDD_0003;
    log_cyc.delete(); log_data.delete(); log_sready.delete();
    log_en = 1;
    send_beat(d, 4'b1010, 1'b1);
    idle();
    drain(50);
    log_en = 0;
    n_cmp++;
    if (log_data.size() != 2) begin
      n_bad++;
      $display("FAIL sparse_count: got %0d outputs, need 2", log_data.size());
    end
  endtask

  task automatic test_backpressure();
    beat_t d;
    for (int i = 0; i < P; i++) d[i] = DW'(32'h30 + i);
    m_if.ready = 1'b0;
    send_beat(d, 4'b1111, 1'b0);
    idle();
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (m_if.valid !== 1'b1 || m_if.data[0] !== 32'h30 || s_if.ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold: got v=%b data=%h sready=%b, need v=1 data=30 sready=0",
                 m_if.valid, m_if.data[0], s_if.ready);
      end
    end
    @(posedge clk);
    #1;
    m_if.ready = 1'b1;
    for (int k = 0; k < P; k++) begin
      #1;
      n_cmp++;
      if (s_if.ready !== (k == P - 1)) begin
        n_bad++;
        $display("FAIL bp_sready lane %0d: got %b, need %b", k, s_if.ready, (k == P - 1));
      end
      @(posedge clk);
      #1;
    end
    drain(20);
  endtask

  task automatic test_zero_mask();
    beat_t d0, d1;
    int    pulses0;
    for (int i = 0; i < P; i++) begin
      d0[i] = DW'(32'h40 + i);
      d1[i] = DW'(32'h50 + i);
    end
    pulses0 = empty_pulses;
    log_cyc.delete(); log_data.delete(); log_sready.delete();
    log_en = 1;
    send_beat(d0, 4'b0000, 1'b1);
    send_beat(d1, 4'b0001, 1'b1);
    idle();
    drain(20);
    repeat (3) @(posedge clk);
    #1;
    log_en = 0;
    n_cmp++;
    if (empty_pulses - pulses0 != 1) begin
      n_bad++;
      $display("FAIL zero_mask_pulse: got %0d pulses, need 1", empty_pulses - pulses0);
    end
    n_cmp++;
    if (log_data.size() != 1) begin
      n_bad++;
      $display("FAIL zero_mask_outputs: got %0d, need 1", log_data.size());
    end
  endtask

  task automatic test_reset_mid_beat();
    beat_t d;
    int    p0, w;
    for (int i = 0; i < P; i++) d[i] = DW'(32'h60 + i);
    m_if.ready = 1'b1;
    p0 = pops;
    send_beat(d, 4'b1111, 1'b1);
    idle();
    w = 0;
    while (pops < p0 + 2 && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (m_if.valid !== 1'b0 || s_if.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b sready=%b, need v=0 sready=1", m_if.valid, s_if.ready);
    end
    n_cmp++;
    if (sb.size() != 2) begin
      n_bad++;
      $display("FAIL mid_reset_emitted: got %0d lanes left, need 2", sb.size());
    end
    sb.delete();
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (m_if.valid !== 1'b0 || s_if.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_idle: got v=%b sready=%b, need v=0 sready=1", m_if.valid, s_if.ready);
    end
  endtask

  task automatic test_random();
    rand_done = 0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          m_if.ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        beat_t d;
        for (int n = 0; n < 10000; n++) begin
          for (int i = 0; i < P; i++) d[i] = $urandom;
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          send_beat(d, P'($urandom), 1'($urandom));
        end
        idle();
        rand_done = 1;
      end
    join
    m_if.ready = 1'b1;
    drain(2000);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (empty_pulses != exp_empty) begin
      n_bad++;
      $display("FAIL empty_last_total: got %0d, need %0d", empty_pulses, exp_empty);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sparse();
    test_backpressure();
    test_zero_mask();
    test_reset_mid_beat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
